// File: rtl/user_counter_bank.sv
// Wishbone-mapped bank of NUM_CH prescaled up/down timer channels with match flags and level IRQs.
// Ack and read data are registered one cycle after the request; a held request acks every other cycle.
module user_counter_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          BITS      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_dat_i,
  input  logic [31:0]            wbs_adr_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [NUM_CH-1:0]      la_data_in,
  input  logic [NUM_CH-1:0]      la_oen,
  output logic [NUM_CH-1:0]      irq_o,
  output logic [NUM_CH*BITS-1:0] count_o
);

  typedef struct packed {
    logic [7:0] prescale;
    logic       ie;
    logic       oneshot;
    logic       dir;
    logic       en;
  } ctrl_t;

  logic                         valid;
  logic                         access;
  logic                         wr_stb;
  logic                         ch_ok;
  logic [3:0]                   ch;
  logic [1:0]                   off;
  logic [31:0]                  be_mask;
  logic [31:0]                  rd_data;
  logic [NUM_CH-1:0][3:0][31:0] rd_word;
  logic                         unused_adr;

  assign valid      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access     = valid & ~wbs_ack_o;
  assign ch         = wbs_adr_i[7:4];
  assign off        = wbs_adr_i[3:2];
  assign ch_ok      = ({1'b0, ch} < 5'(NUM_CH));
  assign wr_stb     = access & wbs_we_i & ch_ok;
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) begin
      be_mask[b*8 +: 8] = {8{wbs_sel_i[b]}};
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_g
    ctrl_t            ctrl_q;
    logic [BITS-1:0]  cnt_q;
    logic [BITS-1:0]  lim_q;
    logic [7:0]       div_q;
    logic             match_q;
    logic [BITS-1:0]  lane_mask;
    logic [BITS-1:0]  cnt_wr;
    logic [BITS-1:0]  lim_wr;
    logic             hit;
    logic             wr_ctrl;
    logic             wr_cnt;
    logic             wr_lim;
    logic             clr_match;
    logic             frozen;
    logic             run;
    logic             tick;
    logic             terminal;
    logic             use_tick;

    assign hit       = wr_stb & (ch == 4'(gi));
    assign wr_ctrl   = hit & (off == 2'd0);
    assign wr_cnt    = hit & (off == 2'd1);
    assign wr_lim    = hit & (off == 2'd2);
    assign clr_match = hit & (off == 2'd3) & wbs_sel_i[0] & wbs_dat_i[0];

    assign lane_mask = be_mask[BITS-1:0];
    assign cnt_wr    = (cnt_q & ~lane_mask) | (wbs_dat_i[BITS-1:0] & lane_mask);
    assign lim_wr    = (lim_q & ~lane_mask) | (wbs_dat_i[BITS-1:0] & lane_mask);

    assign frozen    = ~la_oen[gi] & la_data_in[gi];
    assign run       = ctrl_q.en & ~frozen;
    assign tick      = run & (div_q == ctrl_q.prescale);
    assign terminal  = ctrl_q.dir ? (cnt_q == '0) : (cnt_q == lim_q);
    // A software write to COUNT or CTRL swallows a coincident tick.
    assign use_tick  = tick & ~wr_ctrl & ~wr_cnt;

    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
        ctrl_q  <= '0;
        cnt_q   <= '0;
        lim_q   <= '0;
        div_q   <= '0;
        match_q <= 1'b0;
      end else begin
        if (wr_ctrl) begin
          if (wbs_sel_i[0]) begin
            {ctrl_q.ie, ctrl_q.oneshot, ctrl_q.dir, ctrl_q.en} <= wbs_dat_i[3:0];
          end
          if (wbs_sel_i[1]) begin
            ctrl_q.prescale <= wbs_dat_i[15:8];
          end
        end else if (use_tick && terminal && ctrl_q.oneshot) begin
          ctrl_q.en <= 1'b0;
        end

        if (wr_cnt) begin
          cnt_q <= cnt_wr;
        end else if (use_tick) begin
          if (!terminal) begin
            cnt_q <= ctrl_q.dir ? cnt_q - 1'b1 : cnt_q + 1'b1;
          end else if (!ctrl_q.oneshot) begin
            cnt_q <= ctrl_q.dir ? lim_q : '0;
          end
        end

        if (wr_lim) begin
          lim_q <= lim_wr;
        end

        // A new terminal event outranks a simultaneous clear.
        if (use_tick && terminal) begin
          match_q <= 1'b1;
        end else if (clr_match) begin
          match_q <= 1'b0;
        end

        if (wr_ctrl || wr_cnt || !ctrl_q.en || tick) begin
          div_q <= '0;
        end else if (run) begin
          div_q <= div_q + 8'd1;
        end
      end
    end

    assign rd_word[gi][0] = {16'b0, ctrl_q.prescale, 4'b0,
                             ctrl_q.ie, ctrl_q.oneshot, ctrl_q.dir, ctrl_q.en};
    assign rd_word[gi][1] = 32'(cnt_q);
    assign rd_word[gi][2] = 32'(lim_q);
    assign rd_word[gi][3] = {30'b0, run, match_q};

    assign irq_o[gi]               = match_q & ctrl_q.ie;
    assign count_o[gi*BITS +: BITS] = cnt_q;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 4'(i)) begin
        rd_data = rd_word[i][off];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i && ch_ok) ? rd_data : '0;
    end
  end

  ack_single_cycle: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    wbs_ack_o |=> !wbs_ack_o);

endmodule

// File: tb/tb_user_counter_bank.sv
// Randomised and directed bench for user_counter_bank with a cycle-level reference model and read scoreboard.
module tb_user_counter_bank;
  localparam int          NUM_CH = 4;
  localparam int          BITS   = 16;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int unsigned MASK   = (32'd1 << BITS) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   cyc, stb, we;
  logic [3:0]             sel;
  logic [31:0]            adr, dati;
  logic                   ack;
  logic [31:0]            dato;
  logic [NUM_CH-1:0]      la_data_in, la_oen, irq;
  logic [NUM_CH*BITS-1:0] count;

  user_counter_bank #(.NUM_CH(NUM_CH), .BITS(BITS), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dati), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .la_data_in(la_data_in), .la_oen(la_oen), .irq_o(irq), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-channel architectural state as plain arrays.
  bit          m_en [NUM_CH], m_dir [NUM_CH], m_os [NUM_CH], m_ie [NUM_CH], m_match [NUM_CH];
  int unsigned m_pre [NUM_CH], m_div [NUM_CH], m_cnt [NUM_CH], m_lim [NUM_CH];
  bit          m_ack;

  typedef struct packed { bit is_rd; logic [31:0] dat; } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic bit frozen(input int c);
    return !la_oen[c] && la_data_in[c];
  endfunction

  function automatic logic [31:0] ctrl_word(input int c);
    return (m_pre[c] << 8) | (32'(m_ie[c]) << 3) | (32'(m_os[c]) << 2) | (32'(m_dir[c]) << 1) | 32'(m_en[c]);
  endfunction

  function automatic logic [31:0] m_read(input int c, input int o);
    case (o)
      0:       return ctrl_word(c);
      1:       return m_cnt[c];
      2:       return m_lim[c];
      default: return {30'b0, m_en[c] && !frozen(c), m_match[c]};
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic        acc, okch, hit, wc, wn, wl, wclr, tick, term;
    int          c, o;
    int unsigned nd;
    logic [31:0] w;
    if (!rst_n) begin
      m_ack = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_en[i] = 0; m_dir[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_match[i] = 0;
        m_pre[i] = 0; m_div[i] = 0; m_cnt[i] = 0; m_lim[i] = 0;
      end
    end else begin
      acc  = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
      c    = int'(adr[7:4]);
      o    = int'(adr[3:2]);
      okch = c < NUM_CH;
      if (acc) sb.push_back('{is_rd: !we, dat: (!we && okch) ? m_read(c, o) : 32'h0});
      for (int i = 0; i < NUM_CH; i++) begin
        hit  = acc && we && okch && (c == i);
        wc   = hit && o == 0;
        wn   = hit && o == 1;
        wl   = hit && o == 2;
        wclr = hit && o == 3 && sel[0] && dati[0];
        tick = m_en[i] && !frozen(i) && m_div[i] == m_pre[i];
        term = m_dir[i] ? (m_cnt[i] == 0) : (m_cnt[i] == m_lim[i]);
        if (wc || wn || !m_en[i] || tick) nd = 0;
        else if (!frozen(i))              nd = m_div[i] + 1;
        else                              nd = m_div[i];
        if (wclr) m_match[i] = 0;
        if (tick && !wc && !wn) begin
          if (term) begin
            m_match[i] = 1;
            if (m_os[i]) m_en[i] = 0;
            else         m_cnt[i] = m_dir[i] ? m_lim[i] : 0;
          end else begin
            m_cnt[i] = (m_dir[i] ? m_cnt[i] - 1 : m_cnt[i] + 1) & MASK;
          end
        end
        if (wc) begin
          w = merge(ctrl_word(i), dati, sel);
          m_en[i] = w[0]; m_dir[i] = w[1]; m_os[i] = w[2]; m_ie[i] = w[3];
          m_pre[i] = int'(w[15:8]);
        end
        if (wn) m_cnt[i] = merge(m_cnt[i], dati, sel) & MASK;
        if (wl) m_lim[i] = merge(m_lim[i], dati, sel) & MASK;
        m_div[i] = nd;
      end
      m_ack = acc;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    check("ack", ack, m_ack);
    if (ack) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected at %0t: ack with no pending access", $time);
      end else begin
        e = sb.pop_front();
        if (e.is_rd) check("rdata", dato, e.dat);
      end
    end else begin
      check("dat_idle", dato, 0);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("count%0d", i), count[i*BITS +: BITS], m_cnt[i]);
      check($sformatf("irq%0d", i), irq[i], m_match[i] && m_ie[i]);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit expect_ack);
    bit seen;
    cyc = 1; stb = 1; we = w; adr = a; dati = d; sel = s;
    seen = 0;
    if (expect_ack) begin
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        seen = ack;
      end
      check("ack_timeout", seen, 1);
    end else begin
      repeat (4) @(negedge clk);
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input int c, input int o, input logic [31:0] d, input logic [3:0] s = 4'hf);
    wb_xfer(1, BASE | 32'(c << 4) | 32'(o << 2), d, s, 1);
  endtask

  task automatic rd(input int c, input int o);
    wb_xfer(0, BASE | 32'(c << 4) | 32'(o << 2), 0, 4'hf, 1);
  endtask

  task automatic read_all;
    for (int c = 0; c < NUM_CH; c++) for (int o = 0; o < 4; o++) rd(c, o);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dati = 0;
    la_data_in = '0; la_oen = '1;
    idle(3);
    rst_n = 1;
    idle(1);
    read_all();

    // ch0: auto-reload up counter 0..3, then interrupt and W1C
    wr(0, 2, 3);
    wr(0, 0, 32'h1);
    idle(9);
    wr(0, 0, 32'h9);
    idle(2);
    rd(0, 3);
    wr(0, 3, 32'h1);
    idle(1);
    wr(0, 0, 32'h0);
    wr(0, 3, 32'h1);
    rd(0, 3);

    // ch1: one-shot down count from 5 with prescale 2
    wr(1, 1, 5);
    wr(1, 0, 32'h0207);
    idle(25);
    rd(1, 0); rd(1, 1); rd(1, 3);

    // ch2: byte-lane COUNT write colliding with a tick, then W1C colliding with terminal
    wr(2, 2, 32'hFFFF);
    wr(2, 0, 32'h1);
    idle(6);
    wr(2, 1, 32'h100, 4'b0010);
    idle(2);
    rd(2, 1);
    wr(2, 2, 32'h0);
    idle(2);
    wr(2, 3, 32'h1);
    rd(2, 3);
    wr(2, 0, 32'h0);

    // ch3: freeze through the logic-analyzer probe and resume
    wr(3, 2, 1000);
    wr(3, 0, 32'h1);
    idle(4);
    la_oen[3] = 0; la_data_in[3] = 1;
    rd(3, 3);
    idle(7);
    la_oen[3] = 1; la_data_in[3] = 0;
    idle(5);
    rd(3, 3); rd(3, 1);

    // unmapped channel is acked with zero data; foreign base is never acked
    wr(NUM_CH, 1, 32'hDEAD_BEEF);
    rd(NUM_CH, 1);
    wb_xfer(0, 32'h3000_0104, 0, 4'hf, 0);
    wb_xfer(1, 32'h3100_0004, 32'h55, 4'hf, 0);

    // held request: ack on alternate cycles
    cyc = 1; stb = 1; we = 0; adr = BASE | 32'h4; sel = 4'hf;
    idle(6);
    cyc = 0; stb = 0;
    idle(2);

    for (int n = 0; n < 250; n++) begin
      logic [31:0] a, d;
      a = BASE | 32'($urandom_range(0, NUM_CH) << 4) | 32'($urandom_range(0, 3) << 2);
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d &= 32'h0000_030F;
      if ($urandom_range(0, 9) == 0) begin
        la_oen     = NUM_CH'($urandom);
        la_data_in = NUM_CH'($urandom);
      end
      if ($urandom_range(0, 19) == 0) wb_xfer(0, a ^ 32'h0100_0000, d, 4'hf, 0);
      else wb_xfer(1'($urandom_range(0, 1)), a, d, 4'($urandom), 1);
      idle($urandom_range(0, 3));
    end
    la_oen = '1; la_data_in = '0;
    idle(2);

    // reset asserted while an access is acked
    cyc = 1; stb = 1; we = 1; adr = BASE | 32'h14; dati = 32'h77; sel = 4'hf;
    idle(1);
    rst_n = 0;
    idle(2);
    cyc = 0; stb = 0; we = 0;
    rst_n = 1;
    idle(1);
    read_all();
    idle(2);

    check("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
